// File: rtl/arm_pkg.sv
// arm_pkg: shared fetch-stage types, constants and a saturating-add helper
package arm_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] INST_NOP = 32'h0;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc_next;
  } fetch_entry_t;
  typedef enum logic {RUN, REDIRECT} fetch_state_t;
  function automatic logic [WORD_W-1:0] sat_add(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    logic [WORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WORD_W] ? '1 : s[WORD_W-1:0];
  endfunction
endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if: instruction memory, decode handshake and redirect signals of the fetch stage
interface inst_fetch_ctrl_if #(parameter int DEPTH = 4);
  import arm_pkg::*;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_inst;
  logic [WORD_W-1:0] if_inst;
  logic [WORD_W-1:0] if_pc_next;
  logic if_valid;
  logic if_ready;
  logic branch_taken;
  logic [WORD_W-1:0] branch_addr;
  logic [$clog2(DEPTH):0] q_count;
  modport master (
    output imem_addr, if_inst, if_pc_next, if_valid, q_count,
    input imem_inst, if_ready, branch_taken, branch_addr
  );
  modport slave (
    input imem_addr, if_inst, if_pc_next, if_valid, q_count,
    output imem_inst, if_ready, branch_taken, branch_addr
  );
endinterface

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// fetch_queue: circular prefetch FIFO of fetch entries with single-cycle flush
module fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // flush drops everything by aligning read to write; pointers wrap since DEPTH is a power of two
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d = wr_q;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wr_data;
        wr_d = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end
  // storage is cleared on reset so the head reads as a NOP with pc_next 0
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '{inst: INST_NOP, pc_next: '0}};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign rd_data = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC, redirect FSM and prefetch control for the fetch stage; FETCH_PERF_CNT_EN adds perf counters
module inst_fetch_ctrl
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'd0
) (
  input logic clk,
  input logic rst,
  inst_fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] perf_fetched,
  output logic [WORD_W-1:0] perf_flushed,
  output logic [WORD_W-1:0] perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic push, pop, valid;
  logic [CW-1:0] count;
  fetch_entry_t entry, head;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .flush(bus.branch_taken),
    .push(push),
    .pop(pop),
    .wr_data(entry),
    .rd_data(head),
    .count(count)
  );
  // redirect wins over pop and fetch; otherwise fetch whenever a slot is free or freed this cycle
  always_comb begin
    valid = count != '0;
    pop = valid && bus.if_ready && !bus.branch_taken;
    push = !bus.branch_taken && (state_q == REDIRECT || count != CW'(DEPTH) || pop);
    entry = '{inst: bus.imem_inst, pc_next: pc_q + PC_INC};
    pc_d = bus.branch_taken ? bus.branch_addr & ~32'd3 : push ? entry.pc_next : pc_q;
    state_d = bus.branch_taken ? REDIRECT : RUN;
  end
  // PC and redirect-bubble state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
    end
  end
  assign bus.imem_addr = pc_q;
  assign bus.if_inst = head.inst;
  assign bus.if_pc_next = head.pc_next;
  assign bus.if_valid = valid;
  assign bus.q_count = count;
`ifdef FETCH_PERF_CNT_EN
  logic [WORD_W-1:0] fetched_q, fetched_d, flushed_q, flushed_d, stall_q, stall_d;
  // a redirect discards every queued entry, including the head offered that cycle
  always_comb begin
    fetched_d = sat_add(fetched_q, WORD_W'(push));
    flushed_d = sat_add(flushed_q, bus.branch_taken ? WORD_W'(count) : '0);
    stall_d = sat_add(stall_q, WORD_W'(valid && !bus.if_ready));
  end
  // saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
      stall_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
      stall_q <= stall_d;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_stall = stall_q;
`endif
endmodule
